// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO; Busy is high for MUL_CYCLES/DIV_CYCLES
// cycles from the accept edge. A Start that arrives while Busy is high is dropped, so the hazard unit must hold it.
module mul_div_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [3:0] L_MUL_CNT = 4'(MUL_CYCLES);
  localparam logic [3:0] L_DIV_CNT = 4'(DIV_CYCLES);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_cnt;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;

  logic w_idle_start;
  logic w_accept;
  logic w_mthi;
  logic w_mtlo;
  logic w_done;

  assign w_idle_start = (r_state == S_IDLE) && Start && !clr;
  assign w_accept     = w_idle_start && !Op[2];
  assign w_mthi       = w_idle_start && (Op == 3'd4);
  assign w_mtlo       = w_idle_start && (Op == 3'd5);
  assign w_done       = (r_state == S_RUN) && (r_cnt <= 4'd1) && !clr;

  // Sign/zero-extend to 2*WIDTH so one unsigned multiplier serves MULT and MULTU.
  logic [2*WIDTH-1:0] w_mul_a;
  logic [2*WIDTH-1:0] w_mul_b;
  logic [2*WIDTH-1:0] w_prod;

  assign w_mul_a = r_op[0] ? {{WIDTH{1'b0}}, r_a} : {{WIDTH{r_a[WIDTH-1]}}, r_a};
  assign w_mul_b = r_op[0] ? {{WIDTH{1'b0}}, r_b} : {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_prod  = w_mul_a * w_mul_b;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_uquo;
  logic [WIDTH-1:0] w_urem;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic             w_div_zero;

  // Magnitude division then sign fix-up; the MIN/-1 overflow falls out as MIN with remainder 0.
  assign w_a_neg    = !r_op[0] && r_a[WIDTH-1];
  assign w_b_neg    = !r_op[0] && r_b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -r_a : r_a;
  assign w_b_mag    = w_b_neg ? -r_b : r_b;
  assign w_div_zero = (r_b == '0);
  assign w_uquo     = w_div_zero ? '0 : w_a_mag / w_b_mag;
  assign w_urem     = w_div_zero ? '0 : w_a_mag % w_b_mag;
  assign w_quo      = (w_a_neg ^ w_b_neg) ? -w_uquo : w_uquo;
  assign w_rem      = w_a_neg ? -w_urem : w_urem;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
        S_RUN:   if (r_cnt <= 4'd1) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    Busy     = (r_state == S_RUN);
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (w_done) begin
      if (!r_op[1]) begin
        w_hi_nxt = w_prod[2*WIDTH-1:WIDTH];
        w_lo_nxt = w_prod[WIDTH-1:0];
      end else if (!w_div_zero) begin
        w_hi_nxt = w_rem;
        w_lo_nxt = w_quo;
      end
    end else begin
      if (w_mthi) w_hi_nxt = A;
      if (w_mtlo) w_lo_nxt = A;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (clr) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_op  <= Op[1:0];
        r_a   <= A;
        r_b   <= B;
        r_cnt <= Op[1] ? L_DIV_CNT : L_MUL_CNT;
      end else if ((r_state == S_RUN) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
    end
  end

  assign HI = r_hi;
  assign LO = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed bench for mul_div_unit against a plain-arithmetic HI/LO model.
module tb_mul_div_unit;

  localparam int W     = 32;
  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         clr;
  logic         Start;
  logic [2:0]   Op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Busy;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) u_dut (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .Start (Start),
    .Op    (Op),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural result of one instruction on {HI,LO}.
  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
    longint     sa;
    longint     sb;
    logic [63:0] r;
    r  = {hi, lo};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: r = sa * sb;
      3'd1: r = {32'b0, a} * {32'b0, b};
      3'd2: if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
      3'd3: if (b != 0) r = {a % b, a / b};
      3'd4: r[63:32] = a;
      3'd5: r[31:0] = a;
      default: ;
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [63:0] exp;
    int          cnt;
    exp   = ref_op(op, a, b, m_hi, m_lo);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    step();
    Start = 1'b0;
    if (op < 3'd4) begin
      cnt = 0;
      while (Busy === 1'b1 && cnt < 40) begin
        cnt++;
        check_eq({tag, " hold"}, {HI, LO}, {m_hi, m_lo});
        A = $urandom;
        B = $urandom;
        step();
      end
      check_eq({tag, " busy_cycles"}, 64'(cnt), (op[1] ? 64'(DIV_N) : 64'(MUL_N)));
    end else begin
      check_eq({tag, " busy"}, 64'(Busy), 64'd0);
    end
    check_eq({tag, " hilo"}, {HI, LO}, exp);
    {m_hi, m_lo} = exp;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp;
    logic [63:0] prior;
    int          cnt;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b1; clr = 1'b0; Start = 1'b0; Op = 3'd0; A = '0; B = '0;
    step();
    step();
    check_eq("reset busy", 64'(Busy), 64'd0);
    check_eq("reset hilo", {HI, LO}, 64'd0);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;

    run_op("mthi", 3'd4, 32'h12345678, 32'h0);
    check_eq("mthi const", 64'(HI), 64'h12345678);
    run_op("mtlo", 3'd5, 32'hDEADBEEF, 32'h0);
    check_eq("mtlo const", 64'(LO), 64'hDEADBEEF);

    run_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3);
    check_eq("mult const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
    run_op("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check_eq("multu const", {HI, LO}, 64'hFFFFFFFE_00000001);
    run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2);
    check_eq("div_neg const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
    check_eq("div_ovf const", {HI, LO}, 64'h00000000_80000000);

    run_op("pre_hi", 3'd4, 32'h11, 32'h0);
    run_op("pre_lo", 3'd5, 32'h22, 32'h0);
    run_op("divu_zero", 3'd3, 32'd100, 32'd0);
    check_eq("divu_zero const", {HI, LO}, 64'h00000011_00000022);
    run_op("divu", 3'd3, 32'd100, 32'd7);
    check_eq("divu const", {HI, LO}, 64'h00000002_0000000E);
    run_op("nop", 3'd6, 32'hFFFF0000, 32'h1);

    // Flush two cycles into a MULT.
    prior = {m_hi, m_lo};
    Start = 1'b1; Op = 3'd0; A = 32'd5; B = 32'd5;
    step();
    Start = 1'b0;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("clr busy", 64'(Busy), 64'd0);
    check_eq("clr hilo", {HI, LO}, prior);
    repeat (MUL_N + 2) step();
    check_eq("clr late busy", 64'(Busy), 64'd0);
    check_eq("clr late hilo", {HI, LO}, prior);

    // MTLO mid-run and MTHI on the completion edge must both be dropped.
    exp   = ref_op(3'd2, 32'd1000, 32'hFFFFFFFD, m_hi, m_lo);
    Start = 1'b1; Op = 3'd2; A = 32'd1000; B = 32'hFFFFFFFD;
    step();
    Start = 1'b0;
    cnt   = 0;
    while (Busy === 1'b1 && cnt < 40) begin
      cnt++;
      if (cnt == 3) check_eq("mtlo in run", 64'(LO), 64'(m_lo));
      if (cnt == 2) begin Start = 1'b1; Op = 3'd5; A = 32'hCAFEF00D; end
      if (cnt == DIV_N) begin Start = 1'b1; Op = 3'd4; A = 32'hBAD0BAD0; end
      step();
      Start = 1'b0;
    end
    check_eq("ign busy_cycles", 64'(cnt), 64'(DIV_N));
    check_eq("ign hilo", {HI, LO}, exp);
    step();
    check_eq("ign hilo after", {HI, LO}, exp);
    check_eq("ign busy after", 64'(Busy), 64'd0);
    {m_hi, m_lo} = exp;

    // Reset at cycle 3 of a DIV.
    Start = 1'b1; Op = 3'd2; A = $urandom; B = 32'd3;
    step();
    Start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("rst_run busy", 64'(Busy), 64'd0);
    check_eq("rst_run hilo", {HI, LO}, 64'd0);
    repeat (DIV_N + 2) step();
    check_eq("rst_run late hilo", {HI, LO}, 64'd0);
    m_hi = '0;
    m_lo = '0;

    // Start coincident with clr is dropped.
    run_op("pre_hi2", 3'd4, 32'h55, 32'h0);
    clr = 1'b1; Start = 1'b1; Op = 3'd4; A = 32'h99;
    step();
    check_eq("clr_start mthi", {HI, LO}, {m_hi, m_lo});
    Op = 3'd0; A = 32'd3; B = 32'd3;
    step();
    clr = 1'b0; Start = 1'b0;
    check_eq("clr_start busy", 64'(Busy), 64'd0);
    repeat (MUL_N + 1) step();
    check_eq("clr_start hilo", {HI, LO}, {m_hi, m_lo});

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 9));
        3: rb = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op("rnd", rop, ra, rb);
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers. Sits in the EX stage beside the ALU.
- HI/LO feed the result mux that drives the EX/MEM pipeline register's Data_In.
- Busy goes to the hazard unit, which stalls and clears pipeline registers while an mfhi/mflo/mult/div waits on it.
- MTHI/MTLO write HI/LO directly.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1-15).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1-15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- clr  input  1  synchronous flush; aborts an in-flight operation.
- Start  input  1  single-cycle request; sampled with Op.
- Op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
- A  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- B  input  WIDTH  rt operand (divisor / multiplier).
- Busy  output  1  registered; high while an operation is in flight.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- Reset:
  - reset high at an edge: HI=0, LO=0, Busy=0, internal counter=0, latched operands=0.
  - An in-flight operation is discarded. Initial values are also 0.
- Priority per edge: reset > clr > completion > Start.
- States: IDLE (Busy=0) and RUN (Busy=1).
  - Internal down-counter is 4 bits wide.
  - Op and A/B are latched on accept.
- IDLE, Start=1, Op in {0,1,2,3}:
  - Latch Op, A and B.
  - Load counter with MUL_CYCLES (Op 0-1) or DIV_CYCLES (Op 2-3).
  - Go to RUN; Busy=1 after this edge.
- IDLE, Start=1, Op=4: HI<=A at this edge; no Busy.
- IDLE, Start=1, Op=5: LO<=A at this edge; no Busy.
- Op 6-7: no effect.
- RUN:
  - Counter decrements each edge.
  - On the edge where the counter goes 1->0: write HI/LO, Busy<=0, return to IDLE.
  - Busy is therefore high for exactly N cycles, N = MUL_CYCLES or DIV_CYCLES, counted from the accept edge.
  - HI/LO hold their old values until completion.
- Start while Busy=1 is ignored, including MTHI/MTLO. The hazard unit must hold the instruction.
- Completion and a new Start on the same edge: the Start is ignored, because Busy is still 1 at that edge.
- Arithmetic uses the latched operands only; A/B may change during RUN.
  - MULT: {HI,LO} = signed A * signed B, full 2*WIDTH product.
  - MULTU: {HI,LO} = unsigned A * unsigned B.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIV overflow: A=0x80000000, B=0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: LO = A/B, HI = A%B, unsigned.
  - Divide by zero (B=0, DIV or DIVU): full DIV_CYCLES busy time; HI and LO are left unchanged at completion.
- clr:
  - Any state: Busy<=0, counter<=0, pending result discarded.
  - HI/LO keep their current values.
  - clr together with Start: the Start is dropped, including MTHI/MTLO.
- reset mid-RUN: operation aborted and HI=LO=0 after that edge.
- Outputs are purely registered; no combinational path from inputs to outputs.

Test Plan:
- Reset and MTHI/MTLO:
  - Hold reset 2 cycles -> HI=0, LO=0, Busy=0.
  - Start Op=4 A=0x12345678 -> HI=0x12345678 next cycle, Busy stays 0.
  - Start Op=5 A=0xDEADBEEF -> LO=0xDEADBEEF.
- Signed multiply latency:
  - MULT A=0xFFFFFFFE (-2), B=3 -> Busy high exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - A/B changed to 0 during RUN -> result unaffected.
- Unsigned multiply:
  - MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- Signed division edge cases:
  - DIV A=-7 (0xFFFFFFF9), B=2 -> after 10 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Division by zero and DIVU:
  - Preload HI=0x11, LO=0x22, then DIVU A=100, B=0 -> Busy 10 cycles, HI=0x11, LO=0x22 unchanged.
  - DIVU A=100, B=7 -> LO=14, HI=2.
- Flush, reset, ignored start:
  - MULT A=5, B=5 started; clr at cycle 2 -> Busy=0 next cycle, HI/LO keep prior values.
  - Start with MTLO during RUN -> LO unchanged.
  - reset at cycle 3 of a DIV -> HI=LO=0, Busy=0.
  - Start together with clr -> nothing accepted.
